// File: rtl/serial_rx_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : serial_rx_ctrl
// Purpose  : Asynchronous serial receiver controller. It oversamples SerialIn
//            with CLKS_PER_BIT clocks per bit, frames start/data/stop bits and
//            drives an external bit counter (ClearCounter/IncCounter, read
//            back on Count). Received bytes are offered with a valid/ready
//            handshake. Stop-bit errors and dropped bytes are flagged with
//            one-cycle pulses.
// Ports    : clk          - system clock, rising-edge active
//            reset        - asynchronous active-low reset
//            SerialIn     - asynchronous serial line, idle high
//            Count [7:0]  - current bit index from the external counter
//            DataReady    - downstream accepts RxData when RxValid=1
//            ClearCounter - zero the external bit counter
//            IncCounter   - advance the external bit counter
//            RxData [7:0] - received data, bits >= DATA_BITS read as 0
//            RxValid      - RxData holds a byte not yet accepted
//            FrameError   - pulse: stop bit sampled low
//            Overrun      - pulse: completed byte dropped (RxValid busy)
// Revision : 1.0 - initial release
// ============================================================================
module serial_rx_ctrl #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       SerialIn,
    input  logic [7:0] Count,
    input  logic       DataReady,
    output logic       ClearCounter,
    output logic       IncCounter,
    output logic [7:0] RxData,
    output logic       RxValid,
    output logic       FrameError,
    output logic       Overrun
);

    localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [7:0]        LAST_BIT = 8'(DATA_BITS - 1);
    localparam logic [7:0]        NUM_BITS = 8'(DATA_BITS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] baud_cnt;
    logic             sync_meta;
    logic             rxs;
    logic [7:0]       shift_reg;
    logic             sample_data;
    logic             stop_sample;
    logic             frame_done;
    logic             frame_bad;

    // Two-flop synchronizer; both flops reset to the idle line level so a
    // reset never looks like a falling edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_meta <= 1'b1;
            rxs       <= 1'b1;
        end else begin
            sync_meta <= SerialIn;
            rxs       <= sync_meta;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Baud counter restarts on every state change and also wraps at the end
    // of each bit period so consecutive data bits stay one period apart.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            baud_cnt <= '0;
        end else if ((state_next != state) || (baud_cnt == BIT_END)) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        state_next   = state;
        ClearCounter = 1'b0;
        IncCounter   = 1'b0;
        sample_data  = 1'b0;
        stop_sample  = 1'b0;
        case (state)
            IDLE: begin
                ClearCounter = 1'b1;
                if (!rxs) begin
                    state_next = START;
                end
            end
            START: begin
                // Re-check the line at mid start bit to reject glitches.
                if (baud_cnt == HALF_END) begin
                    state_next = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                // Half-period offset from START puts this at mid data bit.
                if (baud_cnt == BIT_END) begin
                    sample_data = 1'b1;
                    IncCounter  = 1'b1;
                    if (Count == LAST_BIT) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (baud_cnt == BIT_END) begin
                    stop_sample = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign frame_done = stop_sample & rxs;
    assign frame_bad  = stop_sample & ~rxs;

    // Bits at or above DATA_BITS are never written, so they stay 0 from reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_reg <= '0;
        end else if (sample_data && (Count < NUM_BITS)) begin
            shift_reg[Count[2:0]] <= rxs;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            RxData     <= '0;
            RxValid    <= 1'b0;
            FrameError <= 1'b0;
            Overrun    <= 1'b0;
        end else begin
            FrameError <= frame_bad;
            Overrun    <= frame_done & RxValid & ~DataReady;
            if (frame_done && (!RxValid || DataReady)) begin
                // Either the buffer is free or it is being emptied this edge.
                RxData  <= shift_reg;
                RxValid <= 1'b1;
            end else if (RxValid && DataReady) begin
                RxValid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
